leaf_out_arbiter: RTL and testbench
===================================

LEAF_OUT_ARBITER -- requirements
Module: leaf_out_arbiter

Interface
REQ-001 Parameter PACKET_BITS, default 49, BFT packet width.
REQ-002 Parameter PAYLOAD_BITS, default 32, user data width.
REQ-003 Parameter NUM_LEAF_BITS, default 5, destination leaf field width.
REQ-004 Parameter NUM_PORT_BITS, default 4, destination port field width.
REQ-005 Parameter NUM_ADDR_BITS, default 7, sequence field width.
REQ-006 Parameter NUM_OUT_PORTS, default 6, user output channels, range 1..15.
REQ-007 Parameter FREESPACE_INIT, default 64, initial and maximum credits per channel, at most 2^NUM_ADDR_BITS.
REQ-008 Port clk, input, 1, single clock; one clock, all logic on its rising edge.
REQ-009 Port reset, input, 1, asynchronous, active-high reset.
REQ-010 Port din_leaf_bft2interface, input, PACKET_BITS, packets from BFT; config/credit packets are consumed here.
REQ-011 Port din_leaf_user2interface, input, NUM_OUT_PORTS*PAYLOAD_BITS, user payloads; slice i is channel i+1.
REQ-012 Port vld_user2interface, input, NUM_OUT_PORTS, per-channel valid.
REQ-013 Port ack_interface2user, output, NUM_OUT_PORTS, per-channel accept.
REQ-014 Port resend, input, 1, suspends all transmission.
REQ-015 Port dout_leaf_interface2bft, output, PACKET_BITS, packet to BFT.

Function
REQ-016 Packet layout SHALL be {valid[1], leaf[NUM_LEAF_BITS], port[NUM_PORT_BITS], addr[NUM_ADDR_BITS], payload[PAYLOAD_BITS]}, MSB first.
REQ-017 Incoming packet with valid=1 and port field=0 SHALL be a control packet: payload[31:30]=opcode, payload[29:26]=channel index k (0-based).
REQ-018 Opcode 0 (DEST) SHALL load channel k destination {leaf,port} from payload[NUM_LEAF_BITS+NUM_PORT_BITS-1:0] and set its configured flag, effective next cycle.
REQ-019 Opcode 1 (CREDIT) SHALL add payload[NUM_ADDR_BITS:0] to channel k credits, saturating at FREESPACE_INIT.
REQ-020 Opcodes 2/3, k>=NUM_OUT_PORTS, valid=0, or port field!=0 SHALL have no effect.
REQ-021 Channel eligible iff vld=1, configured=1, credits>0, resend=0.
REQ-022 Round-robin: search starts at last-granted+1, wraps modulo NUM_OUT_PORTS; at most one grant per cycle.
REQ-023 ack_interface2user SHALL be combinational, one-hot or zero, asserted only for the granted channel; transfer occurs when vld&ack.
REQ-024 On grant: register packet {1, dest leaf, dest port, seq[k], payload[k]}, decrement credits[k], increment seq[k] (wraps 2^NUM_ADDR_BITS-1 -> 0), update RR pointer.
REQ-025 Latency: grant in cycle N -> packet on dout in cycle N+1; output register is all-zero in any cycle following no grant.
REQ-026 Simultaneous grant and CREDIT on same channel: credits = min(credits-1+inc, FREESPACE_INIT).
REQ-027 Simultaneous DEST and grant on same channel: grant uses old destination.
REQ-028 resend=1: dout_leaf_interface2bft forced to 0 combinationally, no acks, credits/seq/pointer held; control packets still processed.

Reset
REQ-029 Asynchronous reset SHALL set credits=FREESPACE_INIT, configured=0, destinations=0, seq=0, RR pointer=NUM_OUT_PORTS-1 (channel 1 first), output register=0.
REQ-030 During reset ack_interface2user=0 and dout_leaf_interface2bft=0; reset mid-transfer discards the in-flight packet.

Verification
REQ-031 DEST k=0 leaf=3 port=2, vld[0]=1 payload 0xA5A5A5A5 -> next cycle ack[0]=1, following cycle dout={1,3,2,0,0xA5A5A5A5}.
REQ-032 All 6 channels configured and valid continuously -> acks cycle channels 1,2,...,6,1 one per cycle, seq per channel 0,1,2.
REQ-033 Channel 1 sends 64 words with no credit return -> 64 acks then ack[0]=0; CREDIT inc=1 -> exactly one more ack.
REQ-034 resend=1 while channels valid -> dout=0, ack=0, credits unchanged; deassert -> arbitration resumes at saved pointer.
REQ-035 Channel sends 128 words with credits replenished -> addr field wraps 127 -> 0; CREDIT inc=64 at full credits -> stays 64.
REQ-036 Assert reset mid-stream -> dout=0 immediately; after release first grant waits for DEST reconfiguration.

Source files
------------

// File: rtl/leaf_out_arbiter.sv
// Leaf output arbiter: round-robin merge of user channels into one BFT packet stream.
// Each channel has credit-based flow control, a destination set over the network, and a sequence counter.
module leaf_out_arbiter #(
   parameter int PACKET_BITS    = 49,
   parameter int PAYLOAD_BITS   = 32,
   parameter int NUM_LEAF_BITS  = 5,
   parameter int NUM_PORT_BITS  = 4,
   parameter int NUM_ADDR_BITS  = 7,
   parameter int NUM_OUT_PORTS  = 6,
   parameter int FREESPACE_INIT = 64
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [PACKET_BITS-1:0]                din_leaf_bft2interface,
   input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
   input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
   output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
   input  logic                                  resend,
   output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft
);

   localparam int DW    = NUM_LEAF_BITS + NUM_PORT_BITS;
   localparam int CW    = NUM_ADDR_BITS + 1;
   localparam int PTR_W = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
   localparam logic [CW:0]    FS_P  = (CW+1)'(FREESPACE_INIT);
   localparam logic [PTR_W:0] N_P   = (PTR_W+1)'(NUM_OUT_PORTS);
   localparam logic [3:0]     N4_P  = 4'(NUM_OUT_PORTS);

   logic [CW-1:0]            cred_q [NUM_OUT_PORTS];
   logic [CW-1:0]            cred_d [NUM_OUT_PORTS];
   logic [NUM_ADDR_BITS-1:0] seq_q  [NUM_OUT_PORTS];
   logic [NUM_ADDR_BITS-1:0] seq_d  [NUM_OUT_PORTS];
   logic [DW-1:0]            dest_q [NUM_OUT_PORTS];
   logic [DW-1:0]            dest_d [NUM_OUT_PORTS];
   logic [NUM_OUT_PORTS-1:0] cfg_q, cfg_d;
   logic [PTR_W-1:0]         ptr_q, ptr_d;
   logic [PACKET_BITS-1:0]   pkt_q, pkt_d;

   logic [PAYLOAD_BITS-1:0]  user_pl [NUM_OUT_PORTS];
   logic [PAYLOAD_BITS-1:0]  in_pl;
   logic [NUM_PORT_BITS-1:0] in_port;
   logic                     in_valid;
   logic [1:0]               in_op;
   logic [3:0]               in_k;
   logic                     ctrl_hit;
   logic [NUM_OUT_PORTS-1:0] ctrl_sel;
   logic [CW-1:0]            cred_inc;
   logic [NUM_OUT_PORTS-1:0] eligible;
   logic [NUM_OUT_PORTS-1:0] grant_oh;
   logic [PTR_W-1:0]         grant_idx;
   logic                     found;
   logic                     unused_din;

   assign in_valid = din_leaf_bft2interface[PACKET_BITS-1];
   assign in_port  = din_leaf_bft2interface[PAYLOAD_BITS+NUM_ADDR_BITS +: NUM_PORT_BITS];
   assign in_pl    = din_leaf_bft2interface[PAYLOAD_BITS-1:0];
   assign in_op    = in_pl[31:30];
   assign in_k     = in_pl[29:26];
   assign cred_inc = in_pl[NUM_ADDR_BITS:0];
   assign ctrl_hit = in_valid && (in_port == '0) && (in_k < N4_P);
   assign ctrl_sel = ctrl_hit ? (NUM_OUT_PORTS'(1) << in_k) : '0;
   assign unused_din = ^din_leaf_bft2interface;

   always_comb begin
      for (int c = 0; c < NUM_OUT_PORTS; c++) begin
         user_pl[c]  = din_leaf_user2interface[c*PAYLOAD_BITS +: PAYLOAD_BITS];
         eligible[c] = vld_user2interface[c] && cfg_q[c] && (cred_q[c] != '0) && !resend && !reset;
      end
   end

   // Round-robin search begins just past the last granted channel.
   always_comb begin
      logic [PTR_W:0] cand;
      cand      = '0;
      found     = 1'b0;
      grant_idx = '0;
      grant_oh  = '0;
      for (int i = 1; i <= NUM_OUT_PORTS; i++) begin
         cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
         if (cand >= N_P) cand = cand - N_P;
         if (!found && eligible[cand[PTR_W-1:0]]) begin
            found     = 1'b1;
            grant_idx = cand[PTR_W-1:0];
         end
      end
      if (found) grant_oh[grant_idx] = 1'b1;
   end

   always_comb begin
      logic [CW:0] sum;
      sum    = '0;
      cred_d = cred_q;
      seq_d  = seq_q;
      dest_d = dest_q;
      cfg_d  = cfg_q;
      ptr_d  = ptr_q;
      pkt_d  = '0;
      for (int c = 0; c < NUM_OUT_PORTS; c++) begin
         // Grant and credit return on the same channel net out before saturation.
         sum = {1'b0, cred_q[c]};
         if (grant_oh[c]) sum = sum - 1'b1;
         if (ctrl_sel[c] && in_op == 2'd1) sum = sum + {1'b0, cred_inc};
         cred_d[c] = (sum > FS_P) ? FS_P[CW-1:0] : sum[CW-1:0];
         if (ctrl_sel[c] && in_op == 2'd0) begin
            dest_d[c] = in_pl[DW-1:0];
            cfg_d[c]  = 1'b1;
         end
      end
      if (found) begin
         pkt_d            = {1'b1, dest_q[grant_idx], seq_q[grant_idx], user_pl[grant_idx]};
         seq_d[grant_idx] = seq_q[grant_idx] + 1'b1;
         ptr_d            = grant_idx;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < NUM_OUT_PORTS; c++) begin
            cred_q[c] <= FS_P[CW-1:0];
            seq_q[c]  <= '0;
            dest_q[c] <= '0;
         end
         cfg_q <= '0;
         ptr_q <= PTR_W'(NUM_OUT_PORTS-1);
         pkt_q <= '0;
      end else begin
         cred_q <= cred_d;
         seq_q  <= seq_d;
         dest_q <= dest_d;
         cfg_q  <= cfg_d;
         ptr_q  <= ptr_d;
         pkt_q  <= pkt_d;
      end
   end

   assign ack_interface2user      = grant_oh;
   assign dout_leaf_interface2bft = resend ? '0 : pkt_q;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench for leaf_out_arbiter: configuration, round-robin, credits, resend, seq wrap, reset.
module tb_leaf_out_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic [48:0]  din_bft;
   logic [191:0] din_user;
   logic [5:0]   vld;
   logic [5:0]   ack;
   logic         resend;
   logic [48:0]  dout;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] upl   [6];
   logic [4:0]  cleaf [6];
   logic [6:0]  exp_seq;

   always #5 clk = ~clk;

   leaf_out_arbiter dut (
      .clk                     (clk),
      .reset                   (reset),
      .din_leaf_bft2interface  (din_bft),
      .din_leaf_user2interface (din_user),
      .vld_user2interface      (vld),
      .ack_interface2user      (ack),
      .resend                  (resend),
      .dout_leaf_interface2bft (dout)
   );

   function automatic logic [48:0] mkpkt(input logic [4:0] leaf, input logic [3:0] port,
                                         input logic [6:0] seq, input logic [31:0] pl);
      return {1'b1, leaf, port, seq, pl};
   endfunction

   function automatic logic [48:0] mkdest(input logic [3:0] k, input logic [4:0] leaf, input logic [3:0] port);
      return {1'b1, 5'd0, 4'd0, 7'd0, 2'd0, k, 17'd0, leaf, port};
   endfunction

   function automatic logic [48:0] mkcred(input logic [3:0] k, input logic [7:0] inc);
      return {1'b1, 5'd0, 4'd0, 7'd0, 2'd1, k, 18'd0, inc};
   endfunction

   task automatic pulse_reset();
      @(negedge clk);
      vld = '0; din_bft = '0; resend = 1'b0;
      reset = 1'b1;
      #2 reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; resend = 1'b0; vld = 6'h3F; din_bft = mkdest(0, 3, 2);
      #1;
      n_checks++; if (ack !== 6'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 000000", ack); end
      n_checks++; if (dout !== 49'b0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", dout); end
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (dout !== 49'b0) begin n_fail++; $display("FAIL reset_dout_clocked: got %h want 0", dout); end
      @(negedge clk);
      reset = 1'b0; vld = '0; din_bft = '0;
   endtask

   task automatic test_basic();
      @(negedge clk);
      din_bft = mkdest(0, 3, 2); vld = 6'b000001;
      #1;
      n_checks++; if (ack !== 6'b0) begin n_fail++; $display("FAIL basic_unconfigured_ack: got %b want 000000", ack); end
      @(negedge clk);
      din_bft = '0;
      #1;
      n_checks++; if (ack !== 6'b000001) begin n_fail++; $display("FAIL basic_ack: got %b want 000001", ack); end
      @(posedge clk); #1;
      n_checks++; if (dout !== mkpkt(3, 2, 0, 32'hA5A5A5A5)) begin n_fail++; $display("FAIL basic_dout: got %h want %h", dout, mkpkt(3, 2, 0, 32'hA5A5A5A5)); end
      @(negedge clk);
      vld = '0;
      @(posedge clk); #1;
      n_checks++; if (dout !== 49'b0) begin n_fail++; $display("FAIL idle_dout: got %h want 0", dout); end
   endtask

   task automatic test_round_robin_and_resend();
      pulse_reset();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         cleaf[k] = 5'(k + 1);
         din_bft = mkdest(4'(k), cleaf[k], 4'd1);
      end
      @(negedge clk);
      din_bft = '0; vld = 6'h3F;
      for (int j = 0; j < 18; j++) begin
         #1;
         n_checks++; if (ack !== 6'(1 << (j % 6))) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b want %b", j, ack, 6'(1 << (j % 6))); end
         @(posedge clk); #1;
         n_checks++;
         if (dout !== mkpkt(cleaf[j % 6], 4'd1, 7'(j / 6), upl[j % 6])) begin
            n_fail++; $display("FAIL rr_dout[%0d]: got %h want %h", j, dout, mkpkt(cleaf[j % 6], 4'd1, 7'(j / 6), upl[j % 6]));
         end
         @(negedge clk);
      end
      // resend while the output register still holds the last packet
      resend = 1'b1;
      #1;
      n_checks++; if (dout !== 49'b0) begin n_fail++; $display("FAIL resend_dout_comb: got %h want 0", dout); end
      n_checks++; if (ack !== 6'b0) begin n_fail++; $display("FAIL resend_ack: got %b want 000000", ack); end
      repeat (3) begin
         @(posedge clk); #1;
         n_checks++; if (dout !== 49'b0) begin n_fail++; $display("FAIL resend_dout: got %h want 0", dout); end
         @(negedge clk); #1;
         n_checks++; if (ack !== 6'b0) begin n_fail++; $display("FAIL resend_ack_hold: got %b want 000000", ack); end
      end
      resend = 1'b0;
      #1;
      n_checks++; if (ack !== 6'b000001) begin n_fail++; $display("FAIL resume_ack0: got %b want 000001", ack); end
      @(posedge clk); #1;
      n_checks++; if (dout !== mkpkt(cleaf[0], 4'd1, 7'd3, upl[0])) begin n_fail++; $display("FAIL resume_dout0: got %h want %h", dout, mkpkt(cleaf[0], 4'd1, 7'd3, upl[0])); end
      @(negedge clk); #1;
      n_checks++; if (ack !== 6'b000010) begin n_fail++; $display("FAIL resume_ack1: got %b want 000010", ack); end
      @(posedge clk); #1;
      n_checks++; if (dout !== mkpkt(cleaf[1], 4'd1, 7'd3, upl[1])) begin n_fail++; $display("FAIL resume_dout1: got %h want %h", dout, mkpkt(cleaf[1], 4'd1, 7'd3, upl[1])); end
      @(negedge clk);
      vld = '0;
   endtask

   task automatic test_credit_exhaust();
      int cnt;
      pulse_reset();
      @(negedge clk);
      din_bft = mkdest(0, 3, 2);
      @(negedge clk);
      din_bft = '0; vld = 6'b000001;
      cnt = 0;
      for (int i = 0; i < 70; i++) begin
         #1 if (ack[0]) cnt++;
         @(negedge clk);
      end
      n_checks++; if (cnt != 64) begin n_fail++; $display("FAIL credit_exhaust_count: got %0d want 64", cnt); end
      din_bft = mkcred(0, 8'd1);
      #1;
      n_checks++; if (ack !== 6'b0) begin n_fail++; $display("FAIL credit_empty_ack: got %b want 000000", ack); end
      @(negedge clk);
      din_bft = '0;
      #1;
      n_checks++; if (ack !== 6'b000001) begin n_fail++; $display("FAIL credit_one_ack: got %b want 000001", ack); end
      @(posedge clk); #1;
      n_checks++; if (dout !== mkpkt(3, 2, 7'd64, upl[0])) begin n_fail++; $display("FAIL credit_one_dout: got %h want %h", dout, mkpkt(3, 2, 7'd64, upl[0])); end
      @(negedge clk); #1;
      n_checks++; if (ack !== 6'b0) begin n_fail++; $display("FAIL credit_one_only: got %b want 000000", ack); end
   endtask

   task automatic test_seq_wrap_and_saturation();
      int cnt;
      din_bft = mkcred(0, 8'd64);
      @(negedge clk);
      din_bft = mkcred(0, 8'd1);
      exp_seq = 7'd65;
      // a credit of 1 alongside every grant keeps the channel busy through the wrap
      for (int i = 0; i < 70; i++) begin
         #1;
         n_checks++; if (ack !== 6'b000001) begin n_fail++; $display("FAIL wrap_ack[%0d]: got %b want 000001", i, ack); end
         @(posedge clk); #1;
         n_checks++; if (dout[38:32] !== exp_seq) begin n_fail++; $display("FAIL wrap_seq[%0d]: got %0d want %0d", i, dout[38:32], exp_seq); end
         exp_seq = exp_seq + 7'd1;
         @(negedge clk);
      end
      din_bft = mkcred(0, 8'd64); vld = '0;
      @(negedge clk);
      din_bft = '0; vld = 6'b000001;
      cnt = 0;
      for (int i = 0; i < 70; i++) begin
         #1 if (ack[0]) cnt++;
         @(negedge clk);
      end
      n_checks++; if (cnt != 64) begin n_fail++; $display("FAIL credit_saturate_count: got %0d want 64", cnt); end
      exp_seq = exp_seq + 7'd64;
   endtask

   task automatic test_reset_midstream();
      logic [48:0] tmp;
      din_bft = mkcred(0, 8'd8); vld = '0;
      @(negedge clk);
      din_bft = '0; vld = 6'b000001;
      @(posedge clk); #2;
      n_checks++; if (dout !== mkpkt(3, 2, exp_seq, upl[0])) begin n_fail++; $display("FAIL midstream_dout: got %h want %h", dout, mkpkt(3, 2, exp_seq, upl[0])); end
      reset = 1'b1;
      #1;
      n_checks++; if (dout !== 49'b0) begin n_fail++; $display("FAIL reset_dout_immediate: got %h want 0", dout); end
      n_checks++; if (ack !== 6'b0) begin n_fail++; $display("FAIL reset_ack_immediate: got %b want 000000", ack); end
      @(negedge clk);
      reset = 1'b0;
      din_bft = {1'b1, 5'd0, 4'd1, 7'd0, 2'd0, 4'd0, 17'd0, 5'd3, 4'd2};
      #1;
      n_checks++; if (ack !== 6'b0) begin n_fail++; $display("FAIL post_reset_ack: got %b want 000000", ack); end
      @(negedge clk);
      din_bft = mkdest(4'd6, 3, 2);
      @(negedge clk);
      din_bft = {1'b1, 5'd0, 4'd0, 7'd0, 2'd2, 4'd0, 17'd0, 5'd3, 4'd2};
      @(negedge clk);
      tmp = mkdest(0, 3, 2); tmp[48] = 1'b0;
      din_bft = tmp;
      @(negedge clk);
      din_bft = '0;
      #1;
      n_checks++; if (ack !== 6'b0) begin n_fail++; $display("FAIL ignored_ctrl_ack: got %b want 000000", ack); end
      @(negedge clk);
      din_bft = mkdest(0, 7, 5);
      @(negedge clk);
      din_bft = mkdest(0, 9, 4);
      #1;
      n_checks++; if (ack !== 6'b000001) begin n_fail++; $display("FAIL reconfig_ack: got %b want 000001", ack); end
      @(posedge clk); #1;
      n_checks++; if (dout !== mkpkt(7, 5, 0, upl[0])) begin n_fail++; $display("FAIL dest_same_cycle_dout: got %h want %h", dout, mkpkt(7, 5, 0, upl[0])); end
      @(negedge clk);
      din_bft = '0;
      #1;
      n_checks++; if (ack !== 6'b000001) begin n_fail++; $display("FAIL dest_updated_ack: got %b want 000001", ack); end
      @(posedge clk); #1;
      n_checks++; if (dout !== mkpkt(9, 4, 1, upl[0])) begin n_fail++; $display("FAIL dest_updated_dout: got %h want %h", dout, mkpkt(9, 4, 1, upl[0])); end
      @(negedge clk);
      vld = '0;
   endtask

   initial begin
      upl[0] = 32'hA5A5A5A5;
      for (int i = 1; i < 6; i++) upl[i] = 32'hC0DE0000 + 32'(i);
      for (int i = 0; i < 6; i++) din_user[i*32 +: 32] = upl[i];
      test_reset();
      test_basic();
      test_round_robin_and_resend();
      test_credit_exhaust();
      test_seq_wrap_and_saturation();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
